starfield_sequencer: RTL and testbench

- CPU-programmable motion sequencer that drives the starfield's register-write port (addr/data_in/write) autonomously, once per frame.
- Holds a small keyframe table of target speeds, directions and hold times.
- Ramps current speeds toward each target on every vblank rising edge and emits a five-write burst to the starfield.
- Sits between the CPU bus and the starfield, so scene motion needs no per-frame CPU writes.

---
 rtl/starfield_seq_pkg.sv | 31 +++
 rtl/speed_ramp.sv | 59 +++++
 rtl/starfield_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_starfield_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/starfield_seq_pkg.sv
// Shared constants for the starfield motion sequencer.
// CPU map, starfield register map and FSM encoding.
package starfield_seq_pkg;

  localparam logic [3:0] A_CTRL  = 4'd0;
  localparam logic [3:0] A_STEP  = 4'd1;
  localparam logic [3:0] A_WIDX  = 4'd2;
  localparam logic [3:0] A_TH    = 4'd3;
  localparam logic [3:0] A_TV    = 4'd4;
  localparam logic [3:0] A_TF    = 4'd5;
  localparam logic [3:0] A_THOLD = 4'd6;
  localparam logic [3:0] A_COUNT = 4'd7;
  localparam logic [3:0] A_STAT  = 4'd8;
  localparam logic [3:0] A_CURH  = 4'd9;
  localparam logic [3:0] A_CURV  = 4'd10;

  localparam logic [2:0] SF_EN   = 3'd0;
  localparam logic [2:0] SF_HDIR = 3'd1;
  localparam logic [2:0] SF_H    = 3'd2;
  localparam logic [2:0] SF_VDIR = 3'd3;
  localparam logic [2:0] SF_V    = 3'd4;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_UPD  = 3'd1;
  localparam logic [2:0] S_W0   = 3'd2;
  localparam logic [2:0] S_W1   = 3'd3;
  localparam logic [2:0] S_W2   = 3'd4;
  localparam logic [2:0] S_W3   = 3'd5;
  localparam logic [2:0] S_W4   = 3'd6;

endpackage

// File: rtl/speed_ramp.sv
// One motion axis: ramps speed and direction toward a target.
// A direction change always decelerates through zero first.
module speed_ramp (
  input  logic       clk,
  input  logic       rst,
  input  logic       update,
  input  logic [7:0] step,
  input  logic [7:0] target,
  input  logic       target_dir,
  output logic [7:0] cur,
  output logic       cur_dir,
  output logic       at_target
);

  logic [7:0] nxt;
  logic       nxt_dir;
  logic [7:0] dn;

  assign at_target = (cur == target) &&
                     (cur_dir == target_dir);

  assign dn = (cur > step) ? cur - step : 8'd0;

  always_comb begin
    nxt     = cur;
    nxt_dir = cur_dir;
    priority case (1'b1)
      (step == 8'd0): begin
        nxt     = target;
        nxt_dir = target_dir;
      end
      (cur_dir != target_dir && cur != 8'd0): begin
        nxt = dn;
        if (dn == 8'd0) nxt_dir = target_dir;
      end
      (cur_dir != target_dir): begin
        nxt_dir = target_dir;
      end
      (cur < target): begin
        nxt = (target - cur > step) ? cur + step : target;
      end
      (cur > target): begin
        nxt = (cur - target > step) ? cur - step : target;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= '0;
      cur_dir <= 1'b0;
    end else if (update) begin
      cur     <= nxt;
      cur_dir <= nxt_dir;
    end
  end

endmodule

// File: rtl/starfield_sequencer.sv
// Keyframe motion sequencer feeding the starfield register port.
// One five-write burst per vblank rising edge while active.
module starfield_sequencer #(
  parameter int IDX_W   = 3,
  parameter int ENTRIES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblank,
  input  logic [3:0] cpu_addr,
  input  logic [7:0] cpu_data_in,
  input  logic       cpu_write,
  output logic [7:0] cpu_data_out,
  output logic [2:0] sf_addr,
  output logic [7:0] sf_data,
  output logic       sf_write,
  output logic       busy,
  output logic       done
);
  import starfield_seq_pkg::*;

  localparam int CW = IDX_W + 1;
  localparam logic [7:0] ENT8 = 8'(ENTRIES);

  logic [7:0]       tbl_h    [ENTRIES];
  logic [7:0]       tbl_v    [ENTRIES];
  logic [1:0]       tbl_f    [ENTRIES];
  logic [7:0]       tbl_hold [ENTRIES];
  logic             run, loop, sf_en;
  logic [7:0]       step;
  logic [IDX_W-1:0] wr_idx, cur_idx;
  logic [CW-1:0]    count_q, nxt_idx;
  logic [7:0]       hold_cnt;
  logic             held, dirty, pending, vb_q;
  logic [2:0]       state;

  logic       edge_det, ctrl_wr, upd;
  logic       reached, adv, last;
  logic [7:0] cur_h, cur_v;
  logic       cur_hdir, cur_vdir, h_at, v_at;

  assign edge_det = vblank & ~vb_q;
  assign ctrl_wr  = cpu_write && (cpu_addr == A_CTRL);
  assign upd      = (state == S_UPD) && run;
  assign reached  = h_at & v_at;
  assign nxt_idx  = {1'b0, cur_idx} + CW'(1);
  assign last     = nxt_idx >= count_q;
  assign busy     = run;

  always_comb begin
    adv = 1'b0;
    if (reached)
      adv = held ? (hold_cnt == 8'd0)
                 : (tbl_hold[cur_idx] == 8'd0);
  end

  speed_ramp u_h (
    .clk        (clk),
    .rst        (rst),
    .update     (upd),
    .step       (step),
    .target     (tbl_h[cur_idx]),
    .target_dir (tbl_f[cur_idx][0]),
    .cur        (cur_h),
    .cur_dir    (cur_hdir),
    .at_target  (h_at)
  );

  speed_ramp u_v (
    .clk        (clk),
    .rst        (rst),
    .update     (upd),
    .step       (step),
    .target     (tbl_v[cur_idx]),
    .target_dir (tbl_f[cur_idx][1]),
    .cur        (cur_v),
    .cur_dir    (cur_vdir),
    .at_target  (v_at)
  );

  // CPU writes sit after the FSM so they win on a same-cycle clash.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_h[i]    <= '0;
        tbl_v[i]    <= '0;
        tbl_f[i]    <= '0;
        tbl_hold[i] <= '0;
      end
      run      <= 1'b0;
      loop     <= 1'b0;
      sf_en    <= 1'b0;
      step     <= '0;
      wr_idx   <= '0;
      count_q  <= '0;
      cur_idx  <= '0;
      hold_cnt <= '0;
      held     <= 1'b0;
      dirty    <= 1'b0;
      pending  <= 1'b0;
      done     <= 1'b0;
      vb_q     <= 1'b0;
      state    <= S_IDLE;
    end else begin
      vb_q <= vblank;
      if (state != S_IDLE && state != S_W4)
        pending <= pending | edge_det;
      unique case (state)
        S_IDLE:
          if (edge_det && (run || dirty))
            state <= S_UPD;
        S_UPD:
          state <= S_W0;
        S_W4: begin
          dirty   <= 1'b0;
          pending <= 1'b0;
          if ((pending || edge_det) && (run || ctrl_wr))
            state <= S_UPD;
          else
            state <= S_IDLE;
        end
        default:
          state <= state + 3'd1;
      endcase
      if (upd) begin
        if (reached) begin
          if (!held) begin
            held     <= 1'b1;
            hold_cnt <= tbl_hold[cur_idx];
          end else if (hold_cnt != 8'd0) begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end else begin
          held <= 1'b0;
        end
        if (adv) begin
          held <= 1'b0;
          if (!last) begin
            cur_idx <= cur_idx + 1'b1;
          end else if (loop) begin
            cur_idx <= '0;
          end else begin
            run  <= 1'b0;
            done <= 1'b1;
          end
        end
      end
      if (cpu_write) begin
        unique case (cpu_addr)
          A_CTRL: begin
            run   <= cpu_data_in[0];
            loop  <= cpu_data_in[1];
            sf_en <= cpu_data_in[2];
            done  <= 1'b0;
            dirty <= 1'b1;
            if (cpu_data_in[0] && !run) begin
              cur_idx <= '0;
              held    <= 1'b0;
            end
          end
          A_STEP:  step <= cpu_data_in;
          A_WIDX:  wr_idx <= cpu_data_in[IDX_W-1:0];
          A_TH:    tbl_h[wr_idx] <= cpu_data_in;
          A_TV:    tbl_v[wr_idx] <= cpu_data_in;
          A_TF:    tbl_f[wr_idx] <= cpu_data_in[1:0];
          A_THOLD: tbl_hold[wr_idx] <= cpu_data_in;
          A_COUNT: begin
            if (cpu_data_in == 8'd0)
              count_q <= CW'(1);
            else if (cpu_data_in > ENT8)
              count_q <= CW'(ENTRIES);
            else
              count_q <= cpu_data_in[CW-1:0];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_data_out <= '0;
    end else begin
      unique case (cpu_addr)
        A_CTRL:  cpu_data_out <= {5'b0, sf_en, loop, run};
        A_STEP:  cpu_data_out <= step;
        A_WIDX:  cpu_data_out <= 8'(wr_idx);
        A_TH:    cpu_data_out <= tbl_h[wr_idx];
        A_TV:    cpu_data_out <= tbl_v[wr_idx];
        A_TF:    cpu_data_out <= {6'b0, tbl_f[wr_idx]};
        A_THOLD: cpu_data_out <= tbl_hold[wr_idx];
        A_COUNT: cpu_data_out <= 8'(count_q);
        A_STAT:  cpu_data_out <= {done, run, 6'(cur_idx)};
        A_CURH:  cpu_data_out <= cur_h;
        A_CURV:  cpu_data_out <= cur_v;
        default: cpu_data_out <= '0;
      endcase
    end
  end

  always_comb begin
    sf_write = 1'b0;
    sf_addr  = '0;
    sf_data  = '0;
    unique case (state)
      S_W0: begin
        sf_write = 1'b1;
        sf_addr  = SF_EN;
        sf_data  = {7'b0, sf_en};
      end
      S_W1: begin
        sf_write = 1'b1;
        sf_addr  = SF_HDIR;
        sf_data  = {7'b0, cur_hdir};
      end
      S_W2: begin
        sf_write = 1'b1;
        sf_addr  = SF_H;
        sf_data  = cur_h;
      end
      S_W3: begin
        sf_write = 1'b1;
        sf_addr  = SF_VDIR;
        sf_data  = {7'b0, cur_vdir};
      end
      S_W4: begin
        sf_write = 1'b1;
        sf_addr  = SF_V;
        sf_data  = cur_v;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_starfield_sequencer.sv
// Self-checking bench for starfield_sequencer.
// Directed scenarios plus random programs against a frame-level model.
module tb_starfield_sequencer;

  logic       clk = 1'b0;
  logic       rst, vblank, cpu_write;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_data_in, cpu_data_out;
  logic [2:0] sf_addr;
  logic [7:0] sf_data;
  logic       sf_write, busy, done;

  starfield_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .vblank       (vblank),
    .cpu_addr     (cpu_addr),
    .cpu_data_in  (cpu_data_in),
    .cpu_write    (cpu_write),
    .cpu_data_out (cpu_data_out),
    .sf_addr      (sf_addr),
    .sf_data      (sf_data),
    .sf_write     (sf_write),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  // frame-level reference state
  int t_h[8], t_v[8], t_f[8], t_hold[8];
  int m_h, m_hd, m_v, m_vd, m_idx, m_hcnt;
  int m_step, m_count, m_widx;
  bit m_run, m_loop, m_en, m_done, m_dirty, m_held;
  bit ex_burst;
  int ex[5];

  int bw_addr[8], bw_data[8];
  int bw_n, bw_first;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      t_h[i] = 0; t_v[i] = 0;
      t_f[i] = 0; t_hold[i] = 0;
    end
    m_h = 0; m_hd = 0; m_v = 0; m_vd = 0;
    m_idx = 0; m_hcnt = 0; m_step = 0;
    m_count = 0; m_widx = 0;
    m_run = 0; m_loop = 0; m_en = 0;
    m_done = 0; m_dirty = 0; m_held = 0;
  endtask

  task automatic model_wr(int a, int d);
    case (a)
      0: begin
        if ((d & 1) != 0 && !m_run) begin
          m_idx = 0;
          m_held = 0;
        end
        m_run = (d & 1) != 0;
        m_loop = (d & 2) != 0;
        m_en = (d & 4) != 0;
        m_done = 0;
        m_dirty = 1;
      end
      1: m_step = d;
      2: m_widx = d % 8;
      3: t_h[m_widx] = d;
      4: t_v[m_widx] = d;
      5: t_f[m_widx] = d & 3;
      6: t_hold[m_widx] = d;
      7: m_count = (d == 0) ? 1 : (d > 8 ? 8 : d);
      default: ;
    endcase
  endtask

  // speed/direction approach: brake through zero on reversal
  function automatic void ramp(input int c, input int d,
                               input int t, input int td,
                               input int s,
                               output int nc,
                               output int nd);
    nc = c;
    nd = d;
    if (s == 0) begin
      nc = t;
      nd = td;
    end else if (d != td) begin
      nc = (c > s) ? c - s : 0;
      if (nc == 0) nd = td;
    end else if (c < t) begin
      nc = (c + s < t) ? c + s : t;
    end else begin
      nc = (c - s > t) ? c - s : t;
    end
  endfunction

  task automatic model_frame();
    bit reached, adv;
    int cnt, th, tv, tf;
    ex_burst = m_run || m_dirty;
    if (m_run) begin
      th = t_h[m_idx];
      tv = t_v[m_idx];
      tf = t_f[m_idx];
      reached = m_h == th && m_hd == (tf & 1) &&
                m_v == tv && m_vd == (tf >> 1);
      adv = 0;
      if (!reached) m_held = 0;
      else if (!m_held) begin
        m_held = 1;
        m_hcnt = t_hold[m_idx];
        adv = (m_hcnt == 0);
      end else if (m_hcnt > 0) m_hcnt--;
      else adv = 1;
      ramp(m_h, m_hd, th, tf & 1, m_step, m_h, m_hd);
      ramp(m_v, m_vd, tv, tf >> 1, m_step, m_v, m_vd);
      cnt = (m_count == 0) ? 1 : m_count;
      if (adv) begin
        m_held = 0;
        if (m_idx + 1 < cnt) m_idx++;
        else if (m_loop) m_idx = 0;
        else begin
          m_run = 0;
          m_done = 1;
        end
      end
    end
    if (ex_burst) m_dirty = 0;
    ex[0] = m_en;
    ex[1] = m_hd;
    ex[2] = m_h;
    ex[3] = m_vd;
    ex[4] = m_v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(int a, int d);
    cpu_addr = 4'(a);
    cpu_data_in = 8'(d);
    cpu_write = 1'b1;
    tick();
    cpu_write = 1'b0;
    model_wr(a, d);
  endtask

  task automatic cpu_rd(int a, output int d);
    cpu_addr = 4'(a);
    tick();
    d = cpu_data_out;
  endtask

  // raise vblank for hold cycles and record every write seen
  task automatic capture(int hold);
    bw_n = 0;
    bw_first = -1;
    vblank = 1'b1;
    for (int c = 1; c <= hold + 8; c++) begin
      tick();
      if (sf_write) begin
        if (bw_n == 0) bw_first = c;
        if (bw_n < 8) begin
          bw_addr[bw_n] = sf_addr;
          bw_data[bw_n] = sf_data;
        end
        bw_n++;
      end
      if (c == hold) vblank = 1'b0;
    end
  endtask

  task automatic frame_check(string tag, int hold = 1);
    capture(hold);
    model_frame();
    chk({tag, " nwrites"}, bw_n, ex_burst ? 5 : 0);
    if (ex_burst && bw_n == 5) begin
      chk({tag, " latency"}, bw_first, 2);
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("%s addr%0d", tag, i),
            bw_addr[i], i);
        chk($sformatf("%s data%0d", tag, i),
            bw_data[i], ex[i]);
      end
    end
    chk({tag, " busy"}, busy, m_run);
    chk({tag, " done"}, done, m_done);
  endtask

  int rd;
  int exp_up[8] = '{4, 8, 12, 16, 16, 16, 16, 16};
  int exp_rv_h[4] = '{4, 0, 4, 8};
  int exp_rv_d[4] = '{0, 1, 1, 1};
  int exp_lp[6] = '{10, 10, 20, 20, 10, 10};

  initial begin
    rst = 1'b1;
    vblank = 1'b0;
    cpu_write = 1'b0;
    cpu_addr = '0;
    cpu_data_in = '0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      vblank = ~vblank;
      tick();
    end
    chk("rst sf_write", sf_write, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst sf_addr", sf_addr, 0);
    rst = 1'b0;
    vblank = 1'b0;
    tick();
    cpu_rd(8, rd);
    chk("rst status", rd, 0);
    frame_check("idle");

    // ramp up then finish
    cpu_wr(2, 0); cpu_wr(3, 16); cpu_wr(4, 0);
    cpu_wr(5, 0); cpu_wr(6, 2); cpu_wr(1, 4);
    cpu_wr(7, 1); cpu_wr(0, 5);
    cpu_rd(6, rd);
    chk("rd hold", rd, 2);
    for (int f = 0; f < 8; f++) begin
      frame_check($sformatf("up%0d", f));
      chk($sformatf("up%0d h", f), bw_data[2],
          exp_up[f]);
    end
    chk("up done", done, 1);
    chk("up busy", busy, 0);
    frame_check("up end");
    chk("up end quiet", bw_n, 0);

    // reversal through zero
    cpu_wr(0, 0);
    frame_check("stop burst");
    cpu_wr(3, 8); cpu_wr(1, 0); cpu_wr(0, 7);
    frame_check("rv pre");
    chk("rv pre h", bw_data[2], 8);
    cpu_wr(5, 1); cpu_wr(1, 4);
    for (int f = 0; f < 4; f++) begin
      frame_check($sformatf("rv%0d", f));
      chk($sformatf("rv%0d h", f), bw_data[2],
          exp_rv_h[f]);
      chk($sformatf("rv%0d dir", f), bw_data[1],
          exp_rv_d[f]);
    end

    // step 0, looping two entries
    cpu_wr(0, 0);
    frame_check("stop2");
    cpu_wr(1, 0); cpu_wr(7, 2);
    cpu_wr(2, 0); cpu_wr(3, 10); cpu_wr(5, 0);
    cpu_wr(6, 0);
    cpu_wr(2, 1); cpu_wr(3, 20); cpu_wr(4, 0);
    cpu_wr(5, 0); cpu_wr(6, 0);
    cpu_wr(0, 7);
    for (int f = 0; f < 6; f++) begin
      frame_check($sformatf("lp%0d", f));
      chk($sformatf("lp%0d h", f), bw_data[2],
          exp_lp[f]);
      cpu_rd(8, rd);
      chk($sformatf("lp%0d idx", f), rd & 7, m_idx);
    end

    // level held high gives one burst
    frame_check("held", 100);
    chk("held count", bw_n, 5);

    // stop with enable: one dirty burst only
    cpu_wr(0, 4);
    frame_check("dirty");
    chk("dirty en", bw_data[0], 1);
    frame_check("quiet0");
    frame_check("quiet1");
    chk("quiet writes", bw_n, 0);

    // random programs
    for (int t = 0; t < 6; t++) begin
      cpu_wr(0, 0);
      frame_check($sformatf("r%0d stop", t));
      for (int k = 0; k < 8; k++) begin
        cpu_wr(2, k);
        cpu_wr(3, $urandom_range(0, 40));
        cpu_wr(4, $urandom_range(0, 40));
        cpu_wr(5, $urandom_range(0, 3));
        cpu_wr(6, $urandom_range(0, 3));
      end
      cpu_wr(1, $urandom_range(0, 9));
      cpu_wr(7, $urandom_range(0, 10));
      cpu_wr(0, 1 | ($urandom_range(0, 1) << 1) |
                ($urandom_range(0, 1) << 2));
      for (int f = 0; f < 25; f++) begin
        if ($urandom_range(0, 5) == 0) begin
          cpu_wr(2, $urandom_range(0, 7));
          cpu_wr(3, $urandom_range(0, 40));
        end
        frame_check($sformatf("r%0d f%0d", t, f));
      end
      cpu_rd(9, rd);
      chk($sformatf("r%0d cur_h", t), rd, m_h);
      cpu_rd(10, rd);
      chk($sformatf("r%0d cur_v", t), rd, m_v);
    end

    // reset in the middle of a burst
    cpu_wr(0, 1);
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    tick();
    tick();
    chk("mid sf_write", sf_write, 1);
    rst = 1'b1;
    tick();
    chk("mid rst sf_write", sf_write, 0);
    chk("mid rst busy", busy, 0);
    rst = 1'b0;
    model_reset();
    tick();
    cpu_rd(9, rd);
    chk("mid rst cur_h", rd, 0);
    frame_check("post rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
